e_mdu: RTL and testbench

//  Execute-stage multiply/divide unit. It sits beside the E-stage ALU, takes the same forwarded A/B operands, and owns the HI/LO architectural registers.
//  It runs mult/multu/div/divu as a multi-cycle operation with a busy indication, which the hazard unit uses to stall D.
//  It serves mfhi/mflo reads and mthi/mtlo writes; MDUout joins the E->M result mux next to ALUout.

---
 rtl/e_mdu.sv | 121 ++++++++++++
 tb/tb_e_mdu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; mult/div take MULT_CYCLES/DIV_CYCLES busy cycles, result visible the cycle after busy drops.
// No backpressure: busy stalls upstream, and start/mthi/mtlo are ignored while busy.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi_q, lo_q, hi_n, lo_n;
  logic [31:0]   a_q, b_q;
  logic [3:0]    op_q;
  logic          ld;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Full 64-bit products from explicitly extended operands
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide via magnitudes: truncation toward zero, remainder follows dividend;
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign a_mag = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign b_mag = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a_q[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = a_q / b_q;
  assign r_u   = a_q % b_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    ld      = 1'b0;
    case (state)
      IDLE: begin
        if (start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU)) begin
          ld      = 1'b1;
          cnt_n   = (MDUOp == OP_MULT || MDUOp == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_n = BUSY;
        end else if (MDUOp == OP_MTHI) begin
          hi_n = A;
        end else if (MDUOp == OP_MTLO) begin
          lo_n = A;
        end
      end
      BUSY: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          case (op_q)
            OP_MULT:  {hi_n, lo_n} = prod_s;
            OP_MULTU: {hi_n, lo_n} = prod_u;
            OP_DIV:   if (b_q != 32'd0) begin hi_n = r_s; lo_n = q_s; end
            OP_DIVU:  if (b_q != 32'd0) begin hi_n = r_u; lo_n = q_u; end
            default: ;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (ld) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= MDUOp;
      end
    end
  end

  assign busy   = (state == BUSY);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUout = (MDUOp == OP_MFHI) ? hi_q :
                  (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: table of mult/div vectors with a result scoreboard, plus hand sequences
// for mthi/mtlo, ignored start while busy, and reset mid-operation.
module tb_e_mdu;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        start;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, MDUout;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .start(start), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .MDUout(MDUout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the first IDLE cycle after completion.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    int   cyc;
    sb.push_back('{hi: ehi, lo: elo, cyc: (op == MULT || op == MULTU) ? 5 : 10});
    MDUOp = op; start = 1'b1; A = a; B = b;
    @(negedge clk);
    start = 1'b0; MDUOp = NONE; A = $urandom; B = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({name, " busy_cycles"}, 32'(cyc), 32'(e.cyc));
    chk({name, " HI"}, HI, e.hi);
    chk({name, " LO"}, LO, e.lo);
    MDUOp = MFHI; #1;
    chk({name, " mfhi"}, MDUout, e.hi);
    MDUOp = MFLO; #1;
    chk({name, " mflo"}, MDUout, e.lo);
    MDUOp = NONE;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    MDUOp = op; A = a; start = 1'b0;
    @(negedge clk);
    MDUOp = NONE;
  endtask

  initial begin
    vecs[0] = '{MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{DIVU,  32'd7,        32'd2,        32'd1,        32'd3};
    vecs[4] = '{DIV,   32'h12345678, 32'd0,        32'd1,        32'd3};
    vecs[5] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6] = '{MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0,        32'd15};
    vecs[7] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[8] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9] = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};

    reset = 1'b1; MDUOp = NONE; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset MDUout", MDUout, 32'd0);

    // Each op is launched in the first IDLE cycle after the previous one completes
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Divide by zero with known prior HI/LO
    mt(MTHI, 32'hAA);
    mt(MTLO, 32'hBB);
    run_op("div_by_zero", DIV, 32'h12345678, 32'd0, 32'hAA, 32'hBB);

    // mthi then mflo/mfhi
    MDUOp = MTHI; A = 32'hCAFE0000;
    @(negedge clk);
    MDUOp = MFLO; #1;
    chk("mthi mflo_old", MDUout, 32'hBB);
    MDUOp = MFHI; #1;
    chk("mthi mfhi_new", MDUout, 32'hCAFE0000);
    MDUOp = NONE;
    @(negedge clk);

    // start mult and mthi/mtlo while a div is busy: all ignored
    begin
      int cyc;
      MDUOp = DIV; start = 1'b1; A = 32'd100; B = 32'd7;
      @(negedge clk);
      start = 1'b0; MDUOp = NONE;
      @(negedge clk);
      MDUOp = MULT; start = 1'b1; A = 32'd3; B = 32'd3;
      @(negedge clk);
      start = 1'b0; MDUOp = MTHI; A = 32'h5555;
      @(negedge clk);
      MDUOp = MTLO;
      @(negedge clk);
      MDUOp = NONE;
      cyc = 4;
      while (busy === 1'b1 && cyc < 100) begin
        cyc++;
        @(negedge clk);
      end
      chk("busy_ignore cycles", 32'(cyc), 32'd10);
      chk("busy_ignore HI", HI, 32'd2);
      chk("busy_ignore LO", LO, 32'd14);
    end

    // Reset in busy cycle 3 of a mult discards the pending result
    MDUOp = MULT; start = 1'b1; A = 32'd1000; B = 32'd1000;
    @(negedge clk);
    start = 1'b0; MDUOp = NONE;
    chk("pre_reset busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset busy", 32'(busy), 32'd0);
    chk("mid_reset HI", HI, 32'd0);
    chk("mid_reset LO", LO, 32'd0);
    repeat (6) @(negedge clk);
    chk("post_reset no_commit LO", LO, 32'd0);
    chk("post_reset idle", 32'(busy), 32'd0);
    run_op("after_reset", MULT, 32'h00010000, 32'h00010000, 32'd1, 32'd0);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
